// File: rtl/dccm_arbiter.sv
// Single-port DCCM arbiter between the core LSU and a DMA/debug requester:
// fixed LSU priority, DMA starvation guard, DMA burst lock. Define DCCM_ARB_PERF_EN for perf counters.
module dccm_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_BURST    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [1:0]  lsu_store_type,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [1:0]  dma_store_type,
  input  logic        dma_lock,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_rd_addr,
  output logic [31:0] mem_wr_data,
  output logic [1:0]  mem_store_type,
  output logic [1:0]  mem_store_offset,
  input  logic [31:0] mem_rd_data
`ifdef DCCM_ARB_PERF_EN
  ,
  output logic [31:0] perf_lsu_cnt,
  output logic [31:0] perf_dma_cnt,
  output logic [31:0] perf_conflict_cnt
`endif
);

  localparam logic [3:0] STARVE_LIM_W = 4'(STARVE_LIMIT);
  localparam logic [7:0] MAX_BURST_W  = 8'(MAX_BURST);

  typedef enum logic {
    S_ARB,
    S_BURST
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  burst_q, burst_d;
  logic        lsu_prio_q, lsu_prio_d;
  logic        lsu_rd_q, lsu_rd_d;
  logic        dma_rd_q, dma_rd_d;

  // Grant selection and next-state logic.
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    burst_d    = burst_q;
    lsu_prio_d = 1'b0;
    lsu_gnt    = 1'b0;
    dma_gnt    = 1'b0;

    if (!rst) begin
      unique case (state_q)
        S_ARB: begin
          if (lsu_prio_q && lsu_req)                      lsu_gnt = 1'b1;
          else if ((starve_q >= STARVE_LIM_W) && dma_req) dma_gnt = 1'b1;
          else if (lsu_req)                               lsu_gnt = 1'b1;
          else if (dma_req)                               dma_gnt = 1'b1;

          if (dma_gnt && dma_lock) begin
            if (MAX_BURST_W == 8'd1) begin
              // A one-grant burst is already complete; hand the next slot to the LSU.
              lsu_prio_d = 1'b1;
              burst_d    = 8'd0;
            end else begin
              state_d = S_BURST;
              burst_d = 8'd1;
            end
          end
        end

        S_BURST: begin
          dma_gnt = dma_req;
          if (dma_gnt) begin
            if (!dma_lock || (burst_q + 8'd1 == MAX_BURST_W)) begin
              state_d    = S_ARB;
              burst_d    = 8'd0;
              lsu_prio_d = dma_lock;
            end else begin
              burst_d = burst_q + 8'd1;
            end
          end else if (!dma_lock) begin
            state_d = S_ARB;
            burst_d = 8'd0;
          end
        end

        default: state_d = S_ARB;
      endcase

      if (dma_gnt)                            starve_d = 4'd0;
      else if (dma_req && starve_q != 4'hf)   starve_d = starve_q + 4'd1;
    end
  end

  // Memory-side mux: only the granted requester reaches the DCCM pins.
  always_comb begin
    mem_wr_en        = 1'b0;
    mem_rd_en        = 1'b0;
    mem_wr_addr      = 32'd0;
    mem_rd_addr      = 32'd0;
    mem_wr_data      = 32'd0;
    mem_store_type   = 2'd0;
    mem_store_offset = 2'd0;
    if (lsu_gnt) begin
      mem_wr_en        = lsu_we;
      mem_rd_en        = ~lsu_we;
      mem_wr_addr      = {2'b00, lsu_addr[31:2]};
      mem_rd_addr      = {2'b00, lsu_addr[31:2]};
      mem_wr_data      = lsu_wdata;
      mem_store_type   = lsu_store_type;
      mem_store_offset = lsu_addr[1:0];
    end else if (dma_gnt) begin
      mem_wr_en        = dma_we;
      mem_rd_en        = ~dma_we;
      mem_wr_addr      = {2'b00, dma_addr[31:2]};
      mem_rd_addr      = {2'b00, dma_addr[31:2]};
      mem_wr_data      = dma_wdata;
      mem_store_type   = dma_store_type;
      mem_store_offset = dma_addr[1:0];
    end
  end

  assign lsu_rd_d = lsu_gnt & ~lsu_we;
  assign dma_rd_d = dma_gnt & ~dma_we;

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ARB;
      starve_q   <= 4'd0;
      burst_q    <= 8'd0;
      lsu_prio_q <= 1'b0;
      lsu_rd_q   <= 1'b0;
      dma_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      burst_q    <= burst_d;
      lsu_prio_q <= lsu_prio_d;
      lsu_rd_q   <= lsu_rd_d;
      dma_rd_q   <= dma_rd_d;
    end
  end

  // Read data is steered to the owner of the read and held at zero otherwise.
  assign lsu_rvalid = lsu_rd_q;
  assign dma_rvalid = dma_rd_q;
  assign lsu_rdata  = lsu_rd_q ? mem_rd_data : 32'd0;
  assign dma_rdata  = dma_rd_q ? mem_rd_data : 32'd0;

`ifdef DCCM_ARB_PERF_EN
  logic [31:0] perf_lsu_q, perf_lsu_d;
  logic [31:0] perf_dma_q, perf_dma_d;
  logic [31:0] perf_cfl_q, perf_cfl_d;

  always_comb begin
    perf_lsu_d = perf_lsu_q + {31'd0, lsu_gnt};
    perf_dma_d = perf_dma_q + {31'd0, dma_gnt};
    perf_cfl_d = perf_cfl_q + {31'd0, lsu_req & dma_req};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lsu_q <= 32'd0;
      perf_dma_q <= 32'd0;
      perf_cfl_q <= 32'd0;
    end else begin
      perf_lsu_q <= perf_lsu_d;
      perf_dma_q <= perf_dma_d;
      perf_cfl_q <= perf_cfl_d;
    end
  end

  assign perf_lsu_cnt      = perf_lsu_q;
  assign perf_dma_cnt      = perf_dma_q;
  assign perf_conflict_cnt = perf_cfl_q;
`endif

endmodule

// File: tb/tb_dccm_arbiter.sv
// Self-checking bench for dccm_arbiter: directed scenarios plus randomized traffic
// compared against a rule-level reference model of the arbitration policy.
module tb_dccm_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int MAX_BURST    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [1:0]  lsu_store_type;
  logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [1:0]  dma_store_type;
  logic        mem_wr_en, mem_rd_en;
  logic [31:0] mem_wr_addr, mem_rd_addr, mem_wr_data, mem_rd_data;
  logic [1:0]  mem_store_type, mem_store_offset;
`ifdef DCCM_ARB_PERF_EN
  logic [31:0] perf_lsu_cnt, perf_dma_cnt, perf_conflict_cnt;
`endif

  dccm_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_store_type(lsu_store_type), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_store_type(dma_store_type), .dma_lock(dma_lock), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
    .mem_wr_data(mem_wr_data), .mem_store_type(mem_store_type), .mem_store_offset(mem_store_offset),
    .mem_rd_data(mem_rd_data)
`ifdef DCCM_ARB_PERF_EN
    , .perf_lsu_cnt(perf_lsu_cnt), .perf_dma_cnt(perf_dma_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: counts of denied cycles and burst grants, plus pending read owners.
  int denied_cycles;
  int burst_grants;
  bit in_burst;
  bit lsu_owed_slot;
  bit lsu_read_pending;
  bit dma_read_pending;
  bit e_lg, e_dg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    denied_cycles    = 0;
    burst_grants     = 0;
    in_burst         = 0;
    lsu_owed_slot    = 0;
    lsu_read_pending = 0;
    dma_read_pending = 0;
  endtask

  task automatic model_grant();
    e_lg = 0;
    e_dg = 0;
    if (rst)                                             ;
    else if (in_burst)                                   e_dg = dma_req;
    else if (lsu_owed_slot && lsu_req)                   e_lg = 1;
    else if (denied_cycles >= STARVE_LIMIT && dma_req)   e_dg = 1;
    else if (lsu_req)                                    e_lg = 1;
    else if (dma_req)                                    e_dg = 1;
  endtask

  task automatic model_advance();
    if (rst) begin
      model_reset();
      return;
    end
    lsu_read_pending = e_lg && !lsu_we;
    dma_read_pending = e_dg && !dma_we;
    if (!in_burst) lsu_owed_slot = 0;
    if (e_dg) denied_cycles = 0;
    else if (dma_req && denied_cycles < 15) denied_cycles++;
    if (!in_burst) begin
      if (e_dg && dma_lock) begin
        burst_grants = 1;
        if (burst_grants == MAX_BURST) lsu_owed_slot = 1;
        else in_burst = 1;
      end
    end else if (e_dg) begin
      burst_grants++;
      if (!dma_lock) in_burst = 0;
      else if (burst_grants == MAX_BURST) begin
        in_burst      = 0;
        lsu_owed_slot = 1;
      end
    end else if (!dma_lock) begin
      in_burst = 0;
    end
  endtask

  // Let inputs settle, then compare every output against the model.
  task automatic settle(input string tag);
    logic [31:0] ea, ewd;
    logic [1:0]  est, eoff;
    logic        ewe;
    mem_rd_data = $urandom;
    #2;
    model_grant();
    ea = 0; ewd = 0; est = 0; eoff = 0; ewe = 0;
    if (e_lg) begin
      ea = lsu_addr >> 2; ewd = lsu_wdata; est = lsu_store_type; eoff = lsu_addr[1:0]; ewe = lsu_we;
    end else if (e_dg) begin
      ea = dma_addr >> 2; ewd = dma_wdata; est = dma_store_type; eoff = dma_addr[1:0]; ewe = dma_we;
    end
    check({tag, " gnt"}, {30'd0, lsu_gnt, dma_gnt}, {30'd0, e_lg, e_dg});
    check({tag, " en"}, {30'd0, mem_rd_en, mem_wr_en}, {30'd0, (e_lg | e_dg) & ~ewe, (e_lg | e_dg) & ewe});
    check({tag, " rd_addr"}, mem_rd_addr, ea);
    check({tag, " wr_addr"}, mem_wr_addr, ea);
    check({tag, " wr_data"}, mem_wr_data, ewd);
    check({tag, " type_off"}, {28'd0, mem_store_type, mem_store_offset}, {28'd0, est, eoff});
    check({tag, " rvalid"}, {30'd0, lsu_rvalid, dma_rvalid}, {30'd0, lsu_read_pending, dma_read_pending});
    check({tag, " lsu_rdata"}, lsu_rdata, lsu_read_pending ? mem_rd_data : 32'd0);
    check({tag, " dma_rdata"}, dma_rdata, dma_read_pending ? mem_rd_data : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  initial begin
    rst = 1; lsu_req = 0; lsu_we = 0; lsu_addr = 0; lsu_wdata = 0; lsu_store_type = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_store_type = 0; dma_lock = 0;
    mem_rd_data = 0;
    model_reset();

    // Reset with both requesting: no grants, no enables.
    lsu_req = 1; dma_req = 1; dma_lock = 1;
    for (int i = 0; i < 2; i++) begin
      settle("reset");
      check("reset gnt0", {30'd0, lsu_gnt, dma_gnt}, 32'd0);
      tick();
    end
    rst = 0; dma_lock = 0;

    // Both requesting, no lock: L,L,L,L,D repeating.
    for (int i = 0; i < 10; i++) begin
      lsu_addr = $urandom; dma_addr = $urandom;
      settle("pattern");
      check("pattern dma", {31'd0, dma_gnt}, (i % 5 == 4) ? 32'd1 : 32'd0);
      tick();
    end

    // LSU load at 0x104.
    dma_req = 0; lsu_req = 1; lsu_we = 0; lsu_addr = 32'h0000_0104;
    settle("lsu_load");
    check("load rd_addr", mem_rd_addr, 32'h41);
    check("load offset", {30'd0, mem_store_offset}, 32'd0);
    check("load rd_en", {31'd0, mem_rd_en}, 32'd1);
    tick();
    lsu_req = 0;
    settle("lsu_load_rsp");
    check("load lsu_rvalid", {31'd0, lsu_rvalid}, 32'd1);
    check("load lsu_rdata", lsu_rdata, mem_rd_data);
    check("load dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
    tick();

    // DMA byte store at 0x7f03_0003.
    dma_req = 1; dma_we = 1; dma_addr = 32'h7f03_0003; dma_store_type = 0; dma_wdata = 32'hcafe_f00d;
    settle("dma_store");
    check("store wr_en", {31'd0, mem_wr_en}, 32'd1);
    check("store wr_addr", mem_wr_addr, 32'h1fc0_c000);
    check("store offset", {30'd0, mem_store_offset}, 32'd3);
    check("store type", {30'd0, mem_store_type}, 32'd0);
    tick();
    dma_req = 0;
    settle("dma_store_rsp");
    check("store no rvalid", {30'd0, lsu_rvalid, dma_rvalid}, 32'd0);
    tick();

    // Locked burst: 8 DMA grants, one LSU grant, then DMA again.
    dma_req = 1; dma_lock = 1;
    for (int i = 0; i <= 10; i++) begin
      lsu_req = (i >= 1 && i <= 8); dma_we = $urandom; dma_addr = $urandom; lsu_we = $urandom;
      settle("burst");
      check("burst seq", {30'd0, lsu_gnt, dma_gnt}, (i == 8) ? 32'd2 : 32'd1);
      tick();
    end
    dma_req = 0; dma_lock = 0; lsu_req = 0;
    settle("burst_end");
    tick();

    // Reset mid-burst with a read in flight.
    dma_req = 1; dma_lock = 1; dma_we = 0;
    for (int i = 0; i < 5; i++) begin
      dma_addr = $urandom;
      settle("burst5");
      tick();
    end
    rst = 1; lsu_req = 1; lsu_we = 0;
    settle("mid_rst");
    check("mid_rst gnt0", {30'd0, lsu_gnt, dma_gnt}, 32'd0);
    tick();
    rst = 0;
    settle("post_rst");
    check("post_rst rvalid", {30'd0, lsu_rvalid, dma_rvalid}, 32'd0);
    check("post_rst lsu wins", {30'd0, lsu_gnt, dma_gnt}, 32'd2);
    tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      lsu_req = ($urandom_range(0, 3) != 0); dma_req = $urandom; dma_lock = ($urandom_range(0, 2) != 0);
      lsu_we = $urandom; dma_we = $urandom;
      lsu_addr = $urandom; dma_addr = $urandom; lsu_wdata = $urandom; dma_wdata = $urandom;
      lsu_store_type = 2'($urandom_range(0, 2)); dma_store_type = 2'($urandom_range(0, 2));
      settle("rand");
      tick();
    end

`ifdef DCCM_ARB_PERF_EN
    rst = 1; lsu_req = 0; dma_req = 0; dma_lock = 0;
    settle("perf_rst");
    tick();
    rst = 0; lsu_req = 1; dma_req = 1;
    for (int i = 0; i < 20; i++) begin
      settle("perf");
      tick();
    end
    check("perf conflict", perf_conflict_cnt, 32'd20);
    check("perf lsu", perf_lsu_cnt, 32'd16);
    check("perf dma", perf_dma_cnt, 32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
